// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the buffered UART transmitter: byte strobe in, FIFO status out.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              i_wr_en;
  logic [7:0]        i_wr_byte;
  logic              o_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;

  modport master (output i_wr_en, i_wr_byte, input o_full, o_empty, o_count, o_overflow);
  modport slave  (input i_wr_en, i_wr_byte, output o_full, o_empty, o_count, o_overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered 8N1 UART transmitter, LSB first, back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  uart_tx_fifo_if.slave   wr,
  output logic            o_TX_bit,
  output logic            o_transfer_state,
  output logic            o_TX_done
);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [7:0]        shift;
  logic              bit_last, wr_ok, pop;

  assign bit_last = (cnt == CNT_LAST);
  assign wr_ok    = wr.i_wr_en && !wr.o_full;
  // Pop decisions use the registered empty flag, so a byte written into an
  // empty FIFO is only popped on the following edge.
  assign pop      = !wr.o_empty && ((state == S_IDLE) || (state == S_STOP && bit_last));
  assign wr.o_count = count;

  always_comb begin
    count_nxt = count;
    case ({wr_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= wr.i_wr_byte;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      wr.o_full        <= 1'b0;
      wr.o_empty       <= 1'b1;
      wr.o_overflow    <= 1'b0;
      state            <= S_IDLE;
      cnt              <= '0;
      idx              <= '0;
      shift            <= '0;
      o_TX_bit         <= 1'b1;
      o_transfer_state <= 1'b0;
      o_TX_done        <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count         <= count_nxt;
      wr.o_full     <= (count_nxt == CNT_FULL);
      wr.o_empty    <= (count_nxt == '0);
      wr.o_overflow <= wr.o_overflow | (wr.i_wr_en & wr.o_full);

      // Registered one cycle early so the pulse lands on the final STOP cycle.
      o_TX_done <= (state == S_STOP) && (cnt == CNT_DONE);

      if (state != S_IDLE) cnt <= bit_last ? '0 : cnt + 1'b1;
      if (pop) shift <= mem[rd_ptr];

      case (state)
        S_IDLE: if (pop) begin
          state            <= S_START;
          o_TX_bit         <= 1'b0;
          o_transfer_state <= 1'b1;
        end
        S_START: if (bit_last) begin
          state    <= S_DATA;
          idx      <= '0;
          o_TX_bit <= shift[0];
        end
        S_DATA: if (bit_last) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state    <= S_PARITY;
            o_TX_bit <= ^shift;
`else
            state    <= S_STOP;
            o_TX_bit <= 1'b1;
`endif
          end else begin
            idx      <= idx + 3'd1;
            o_TX_bit <= shift[idx + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (bit_last) begin
          state    <= S_STOP;
          o_TX_bit <= 1'b1;
        end
`endif
        S_STOP: if (bit_last) begin
          if (pop) begin
            state    <= S_START;
            o_TX_bit <= 1'b0;
          end else begin
            state            <= S_IDLE;
            o_TX_bit         <= 1'b1;
            o_transfer_state <= 1'b0;
          end
        end
        default: begin
          state            <= S_IDLE;
          o_TX_bit         <= 1'b1;
          o_transfer_state <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the FFT result path: accepts bytes through a single-cycle write strobe into an internal FIFO and serialises them as 8N1 frames, LSB first, on one line. It is the outbound counterpart of the UART receiver. Frames are sent back-to-back with no idle gap while the FIFO holds data, so the FFT core can dump a burst of result bytes without per-byte handshaking.

## Interface
- CLKS_PER_BIT, 434, clock cycles per bit (115200 baud at 50 MHz); minimum 2
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2
- ADDR_W, 4, log2(FIFO_DEPTH)

- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous reset, active-low
- i_wr_en  in  1  write strobe; one byte per cycle while high
- i_wr_byte  in  8  byte to enqueue
- o_full  out  1  FIFO full
- o_empty  out  1  FIFO empty
- o_count  out  ADDR_W+1  FIFO occupancy, 0..FIFO_DEPTH
- o_overflow  out  1  sticky: a write was dropped because the FIFO was full
- o_TX_bit  out  1  serial line; idle high
- o_transfer_state  out  1  high while a frame is on the line (START through STOP)
- o_TX_done  out  1  one-cycle pulse at the end of each stop bit

## Operation
- Reset, sampled at a rising edge with i_rst_n=0, sets:
  - o_TX_bit=1, o_transfer_state=0, o_TX_done=0
  - o_full=0, o_empty=1, o_count=0, o_overflow=0
  - FSM to IDLE; FIFO pointers and bit/baud counters to 0
- Reset mid-frame aborts the frame. The line returns high on that edge and FIFO contents are discarded.
- Write rule:
  - a write is accepted iff i_wr_en=1 and o_full=0 at that edge
  - otherwise the byte is dropped and o_overflow is set (sticky until reset)
  - when the FIFO is full, a write and a pop on the same edge still drop the write
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE: line high. If !o_empty, pop the head byte into the shift register and go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line = shift[idx] for CLKS_PER_BIT cycles per bit, idx 0..7. After bit 7, go to STOP (or PARITY).
  - STOP: line 1 for CLKS_PER_BIT cycles. On the last cycle, pulse o_TX_done. If !o_empty, pop and go directly to START; otherwise go to IDLE.
- Pop and write on the same edge, FIFO neither empty nor full: o_count is unchanged.
- A write into an empty FIFO is never popped on the same edge. The pop occurs on the following edge.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps. The FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- A write accepted at edge N updates o_count/o_empty after edge N. If the FSM is IDLE, the pop happens at edge N+1 and o_TX_bit falls after edge N+1.
- Frame length is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
- o_transfer_state is high for the whole frame. It stays high across back-to-back frames, with no gap cycle.
- o_TX_done is high for exactly one cycle per frame, coincident with the final STOP cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- UART_TX_PARITY_EN defined:
  - a PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles
  - the line carries even parity, i.e. the XOR of the 8 data bits
  - frame length is 11 bits
- Not defined: the PARITY state and its logic are absent, and the frame is 8N1.

## Test plan
- CLKS_PER_BIT=4, write 0xB5 once → after 1 cycle the line carries 0, 1,0,1,0,1,1,0,1, 1, each bit 4 cycles; o_TX_done pulses once at cycle 40 of the frame; o_empty=1 afterwards.
- Write 0xB5 then 0x82 on consecutive cycles → the second frame (0, 0,1,0,0,0,0,0,1, 1) starts on the cycle after the first stop bit; o_transfer_state never drops; two o_TX_done pulses 40 cycles apart.
- While the FSM is busy, write 17 bytes with FIFO_DEPTH=16 → o_full=1 after 16, the 17th is dropped, o_overflow=1; exactly 16 frames are transmitted.
- Write on the same edge as a pop with o_count=3 → o_count stays 3; the byte order on the line is preserved.
- Assert i_rst_n=0 for one cycle during DATA bit 3 → line=1 on the next cycle, o_count=0, o_transfer_state=0; no o_TX_done pulse.
- With UART_TX_PARITY_EN, send 0xB5 then 0x82 → parity bits are 1 and 0; frames are 44 cycles each.
